u_idu_dispatcher: RTL and testbench

Dual-issue in-order dispatch controller in the IDU. It buffers fetched instructions in a small FIFO and presents the two oldest to the two per-slot bypass MUX instances as rs1/rs2 indices. It resolves intra-pair RAW hazards and the bypass MUX stall requests, then registers 0, 1 or 2 instructions per cycle into the ID/EX pipe registers. Slot 0 is always the older instruction.

---
 rtl/u_idu_dispatcher.sv | 158 +++++++++++++++
 tb/tb_u_idu_dispatcher.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/u_idu_dispatcher.sv
// Dual-issue in-order dispatcher: instruction FIFO, head decode,
// intra-pair hazard / stall resolution and ID/EX issue registers.
module u_idu_dispatcher #(
    parameter int DATA_WIDTH   = 32,
    parameter int RF_DEPTH_BIT = 5,
    parameter int FIFO_DEPTH   = 4,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              ifu_idu_inst_vld,
    input  logic [DATA_WIDTH-1:0]   ifu_idu_inst [2],
    input  logic [DATA_WIDTH-1:0]   ifu_idu_pc [2],
    output logic                    idu_ifu_ready,
    input  logic                    ctrl_idu_flush,
    output logic [RF_DEPTH_BIT-1:0] idu_byp_rs1_idx [2],
    output logic [RF_DEPTH_BIT-1:0] idu_byp_rs2_idx [2],
    output logic                    idu_byp_rs1_idx_vld [2],
    output logic                    idu_byp_rs2_idx_vld [2],
    input  logic [1:0]              byp_idu_stall_vld,
    output logic                    idu_iex_pipe_vld [2],
    output logic [DATA_WIDTH-1:0]   idu_iex_inst [2],
    output logic [DATA_WIDTH-1:0]   idu_iex_pc [2],
    output logic [RF_DEPTH_BIT-1:0] idu_iex_rd [2],
    output logic                    idu_iex_rd_vld [2],
    output logic [CNT_WIDTH-1:0]    idu_perf_stall_cnt
);

    localparam int PW = $clog2(FIFO_DEPTH);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    logic [DATA_WIDTH-1:0]   inst_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]   pc_q [FIFO_DEPTH];
    logic [PW-1:0]           rd_ptr;
    logic [PW-1:0]           wr_ptr;
    logic [PW:0]             count;

    logic [DATA_WIDTH-1:0]   h_inst [2];
    logic [DATA_WIDTH-1:0]   h_pc [2];
    logic [6:0]              h_op [2];
    logic                    h_vld [2];
    logic                    s1_vld [2];
    logic                    s2_vld [2];
    logic                    d_vld [2];
    logic [RF_DEPTH_BIT-1:0] s1 [2];
    logic [RF_DEPTH_BIT-1:0] s2 [2];
    logic [RF_DEPTH_BIT-1:0] d [2];

    logic                    hazard;
    logic [1:0]              issue;
    logic [1:0]              n_pop;
    logic [1:0]              n_push;
    logic                    push_ok;
    logic [PW-1:0]           wa1;

    assign idu_ifu_ready = count <= (PW+1)'(FIFO_DEPTH - 2);

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            h_inst[i] = inst_q[rd_ptr + PW'(i)];
            h_pc[i]   = pc_q[rd_ptr + PW'(i)];
            h_op[i]   = h_inst[i][6:0];
            h_vld[i]  = count > (PW+1)'(i);
            s1[i]     = RF_DEPTH_BIT'(h_inst[i][19:15]);
            s2[i]     = RF_DEPTH_BIT'(h_inst[i][24:20]);
            d[i]      = RF_DEPTH_BIT'(h_inst[i][11:7]);
            s1_vld[i] = h_vld[i] && h_op[i] != OPC_LUI
                        && h_op[i] != OPC_AUIPC && h_op[i] != OPC_JAL;
            s2_vld[i] = h_vld[i] && (h_op[i] == OPC_OP
                        || h_op[i] == OPC_STORE || h_op[i] == OPC_BRANCH);
            d_vld[i]  = h_vld[i] && h_op[i] != OPC_STORE
                        && h_op[i] != OPC_BRANCH && d[i] != '0;
            idu_byp_rs1_idx[i]     = h_vld[i] ? s1[i] : '0;
            idu_byp_rs2_idx[i]     = h_vld[i] ? s2[i] : '0;
            idu_byp_rs1_idx_vld[i] = s1_vld[i];
            idu_byp_rs2_idx_vld[i] = s2_vld[i];
        end
    end

    // Slot 1 may not consume a register slot 0 is writing this cycle.
    assign hazard = d_vld[0] && ((s1_vld[1] && s1[1] == d[0])
                              || (s2_vld[1] && s2[1] == d[0]));

    assign issue[0] = h_vld[0] && !byp_idu_stall_vld[0] && !ctrl_idu_flush;
    assign issue[1] = issue[0] && h_vld[1] && !byp_idu_stall_vld[1] && !hazard;

    assign n_pop   = {1'b0, issue[0]} + {1'b0, issue[1]};
    assign push_ok = idu_ifu_ready && !ctrl_idu_flush;
    assign n_push  = push_ok ? {1'b0, ifu_idu_inst_vld[0]}
                             + {1'b0, ifu_idu_inst_vld[1]} : 2'd0;
    assign wa1     = wr_ptr + PW'(ifu_idu_inst_vld[0]);

    always_ff @(posedge clk) begin
        if (push_ok && ifu_idu_inst_vld[0]) begin
            inst_q[wr_ptr] <= ifu_idu_inst[0];
            pc_q[wr_ptr]   <= ifu_idu_pc[0];
        end
        if (push_ok && ifu_idu_inst_vld[1]) begin
            inst_q[wa1] <= ifu_idu_inst[1];
            pc_q[wa1]   <= ifu_idu_pc[1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (ctrl_idu_flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + PW'(n_pop);
            wr_ptr <= wr_ptr + PW'(n_push);
            count  <= count + (PW+1)'(n_push) - (PW+1)'(n_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                idu_iex_pipe_vld[i] <= 1'b0;
                idu_iex_inst[i]     <= '0;
                idu_iex_pc[i]       <= '0;
                idu_iex_rd[i]       <= '0;
                idu_iex_rd_vld[i]   <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                idu_iex_pipe_vld[i] <= issue[i];
                if (issue[i]) begin
                    idu_iex_inst[i]   <= h_inst[i];
                    idu_iex_pc[i]     <= h_pc[i];
                    idu_iex_rd[i]     <= d[i];
                    idu_iex_rd_vld[i] <= d_vld[i];
                end
            end
        end
    end

    // Counts cycles lost with work pending; survives flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idu_perf_stall_cnt <= '0;
        end else if (count != '0 && !issue[0] && !ctrl_idu_flush
                     && idu_perf_stall_cnt != '1) begin
            idu_perf_stall_cnt <= idu_perf_stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_u_idu_dispatcher.sv
// Bench for u_idu_dispatcher: queue-based reference model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_u_idu_dispatcher;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  inst_vld;
    logic [31:0] inst [2];
    logic [31:0] pc [2];
    logic        ready;
    logic        flush;
    logic [4:0]  rs1_idx [2];
    logic [4:0]  rs2_idx [2];
    logic        rs1_vld [2];
    logic        rs2_vld [2];
    logic [1:0]  stall;
    logic        pipe_vld [2];
    logic [31:0] iex_inst [2];
    logic [31:0] iex_pc [2];
    logic [4:0]  iex_rd [2];
    logic        iex_rd_vld [2];
    logic [15:0] stall_cnt;

    int total = 0;
    int bad = 0;
    logic [31:0] pcn = 32'h100;

    u_idu_dispatcher dut (
        .clk(clk), .rst(rst),
        .ifu_idu_inst_vld(inst_vld),
        .ifu_idu_inst(inst), .ifu_idu_pc(pc),
        .idu_ifu_ready(ready), .ctrl_idu_flush(flush),
        .idu_byp_rs1_idx(rs1_idx), .idu_byp_rs2_idx(rs2_idx),
        .idu_byp_rs1_idx_vld(rs1_vld), .idu_byp_rs2_idx_vld(rs2_vld),
        .byp_idu_stall_vld(stall),
        .idu_iex_pipe_vld(pipe_vld), .idu_iex_inst(iex_inst),
        .idu_iex_pc(iex_pc), .idu_iex_rd(iex_rd),
        .idu_iex_rd_vld(iex_rd_vld), .idu_perf_stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;

    ent_t        q[$];
    logic        e_vld [2];
    logic [31:0] e_inst [2];
    logic [31:0] e_pc [2];
    logic [4:0]  e_rd [2];
    logic        e_rdv [2];
    logic [15:0] e_cnt;

    function automatic bit reads1(input logic [31:0] x);
        return !(x[6:0] inside {7'b0110111, 7'b0010111, 7'b1101111});
    endfunction

    function automatic bit reads2(input logic [31:0] x);
        return x[6:0] inside {7'b0110011, 7'b0100011, 7'b1100011};
    endfunction

    function automatic bit writes(input logic [31:0] x);
        return !(x[6:0] inside {7'b0100011, 7'b1100011}) && x[11:7] != 0;
    endfunction

    function automatic bit depends(input logic [31:0] y, input logic [31:0] o);
        return writes(o) && ((reads1(y) && y[19:15] == o[11:7])
                          || (reads2(y) && y[24:20] == o[11:7]));
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            e_cnt = 0;
            for (int i = 0; i < 2; i++) begin
                e_vld[i] = 0; e_inst[i] = 0; e_pc[i] = 0;
                e_rd[i] = 0; e_rdv[i] = 0;
            end
        end else begin
            int n;
            int sz;
            n = 0;
            sz = q.size();
            if (!flush && sz > 0 && !stall[0]) begin
                n = 1;
                if (sz > 1 && !stall[1] && !depends(q[1].inst, q[0].inst))
                    n = 2;
            end
            for (int i = 0; i < 2; i++) begin
                e_vld[i] = (i < n);
                if (i < n) begin
                    e_inst[i] = q[i].inst;
                    e_pc[i]   = q[i].pc;
                    e_rd[i]   = q[i].inst[11:7];
                    e_rdv[i]  = writes(q[i].inst);
                end
            end
            if (sz > 0 && n == 0 && !flush && e_cnt != 16'hFFFF)
                e_cnt = e_cnt + 1;
            for (int i = 0; i < n; i++) void'(q.pop_front());
            if (flush) begin
                q.delete();
            end else if (4 - sz >= 2) begin
                if (inst_vld[0]) q.push_back('{inst[0], pc[0]});
                if (inst_vld[1]) q.push_back('{inst[1], pc[1]});
            end
        end
    end

    always @(negedge clk) begin
        chk("ready", ready, (4 - q.size()) >= 2);
        chk("stall_cnt", stall_cnt, e_cnt);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("pipe_vld%0d", i), pipe_vld[i], e_vld[i]);
            chk($sformatf("iex_inst%0d", i), iex_inst[i], e_inst[i]);
            chk($sformatf("iex_pc%0d", i), iex_pc[i], e_pc[i]);
            chk($sformatf("iex_rd%0d", i), iex_rd[i], e_rd[i]);
            chk($sformatf("iex_rd_vld%0d", i), iex_rd_vld[i], e_rdv[i]);
            if (q.size() > i) begin
                chk($sformatf("rs1_vld%0d", i), rs1_vld[i], reads1(q[i].inst));
                chk($sformatf("rs2_vld%0d", i), rs2_vld[i], reads2(q[i].inst));
                if (reads1(q[i].inst))
                    chk($sformatf("rs1_idx%0d", i), rs1_idx[i], q[i].inst[19:15]);
                if (reads2(q[i].inst))
                    chk($sformatf("rs2_idx%0d", i), rs2_idx[i], q[i].inst[24:20]);
            end else begin
                chk($sformatf("rs1_vld%0d_empty", i), rs1_vld[i], 1'b0);
                chk($sformatf("rs2_vld%0d_empty", i), rs2_vld[i], 1'b0);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    localparam logic [31:0] ADDI1 = 32'h00500093;
    localparam logic [31:0] ADDI2 = 32'h00700113;
    localparam logic [31:0] ADDI3 = 32'h00100193;
    localparam logic [31:0] ADD4  = 32'h00318233;
    localparam logic [31:0] LW5   = 32'h0000A283;
    localparam logic [31:0] ADD6  = 32'h00208333;
    localparam logic [31:0] ADDIA = 32'h00100513;
    localparam logic [31:0] ADDB  = 32'h00D605B3;
    localparam logic [31:0] LUI5  = 32'h123452B7;
    localparam logic [31:0] SW    = 32'h0020A223;
    localparam logic [31:0] BEQ   = 32'h00208063;
    localparam logic [31:0] JAL1  = 32'h000000EF;

    task automatic step(input logic [1:0] v, input logic [31:0] i0,
                        input logic [31:0] i1, input logic [1:0] st,
                        input logic fl);
        inst_vld = v;
        inst[0] = i0; inst[1] = i1;
        pc[0] = pcn; pc[1] = pcn + 4;
        pcn = pcn + 8;
        stall = st;
        flush = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        inst_vld = 0; inst[0] = 0; inst[1] = 0;
        pc[0] = 0; pc[1] = 0; stall = 0; flush = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", ready, 1'b1);
        chk("rst_pipe_vld0", pipe_vld[0], 1'b0);
        chk("rst_cnt", stall_cnt, 16'd0);
        chk("rst_rs1_vld0", rs1_vld[0], 1'b0);
        rst = 1'b0;

        // independent pair
        step(2'b11, ADDI1, ADDI2, 2'b00, 0);
        step(2'b00, 0, 0, 2'b00, 0);
        chk("pair_vld0", pipe_vld[0], 1'b1);
        chk("pair_vld1", pipe_vld[1], 1'b1);
        chk("pair_rd0", iex_rd[0], 5'd1);
        chk("pair_rd1", iex_rd[1], 5'd2);
        chk("pair_ready", ready, 1'b1);

        // intra-pair RAW
        step(2'b11, ADDI3, ADD4, 2'b00, 0);
        step(2'b00, 0, 0, 2'b00, 0);
        chk("raw1_vld0", pipe_vld[0], 1'b1);
        chk("raw1_vld1", pipe_vld[1], 1'b0);
        chk("raw1_rd0", iex_rd[0], 5'd3);
        step(2'b00, 0, 0, 2'b00, 0);
        chk("raw2_inst0", iex_inst[0], ADD4);
        chk("raw2_vld1", pipe_vld[1], 1'b0);
        chk("raw2_rd0", iex_rd[0], 5'd4);

        // load-use stall on slot 0
        step(2'b11, LW5, ADD6, 2'b01, 0);
        step(2'b00, 0, 0, 2'b01, 0);
        chk("lu_rs1_idx0_a", rs1_idx[0], 5'd1);
        step(2'b00, 0, 0, 2'b01, 0);
        chk("lu_cnt", stall_cnt, 16'd2);
        chk("lu_rs1_idx0_b", rs1_idx[0], 5'd1);
        chk("lu_rs2_vld0", rs2_vld[0], 1'b0);
        chk("lu_rs2_idx1", rs2_idx[1], 5'd2);
        chk("lu_nvld0", pipe_vld[0], 1'b0);
        step(2'b00, 0, 0, 2'b00, 0);
        chk("lu_go_vld0", pipe_vld[0], 1'b1);
        chk("lu_go_vld1", pipe_vld[1], 1'b1);
        chk("lu_go_inst1", iex_inst[1], ADD6);

        // stall on slot 1 only
        step(2'b11, ADDIA, ADDB, 2'b10, 0);
        step(2'b00, 0, 0, 2'b10, 0);
        chk("s1_vld0", pipe_vld[0], 1'b1);
        chk("s1_vld1", pipe_vld[1], 1'b0);
        chk("s1_rd0", iex_rd[0], 5'd10);
        chk("s1_head_rs1", rs1_idx[0], 5'd12);
        chk("s1_head_rs2", rs2_idx[0], 5'd13);
        step(2'b00, 0, 0, 2'b00, 0);
        chk("s1_next_rd0", iex_rd[0], 5'd11);

        // fill, drop while full, drain with wrap, flush
        step(2'b11, LUI5, SW, 2'b01, 0);
        step(2'b11, BEQ, JAL1, 2'b01, 0);
        chk("full_ready", ready, 1'b0);
        chk("full_cnt", stall_cnt, 16'd3);
        step(2'b11, ADDIA, ADDIA, 2'b01, 0);
        chk("drop_ready", ready, 1'b0);
        chk("drop_cnt", stall_cnt, 16'd4);
        chk("drop_lui_rs1v", rs1_vld[0], 1'b0);
        chk("drop_sw_rs2", rs2_idx[1], 5'd2);
        step(2'b00, 0, 0, 2'b00, 0);
        chk("drain_ready", ready, 1'b1);
        chk("drain_inst0", iex_inst[0], LUI5);
        chk("drain_inst1", iex_inst[1], SW);
        chk("drain_rdv1", iex_rd_vld[1], 1'b0);
        step(2'b11, ADDI1, ADDI2, 2'b00, 0);
        chk("wrap_inst0", iex_inst[0], BEQ);
        chk("wrap_inst1", iex_inst[1], JAL1);
        chk("wrap_rdv0", iex_rd_vld[0], 1'b0);
        chk("wrap_rdv1", iex_rd_vld[1], 1'b1);
        chk("wrap_head_rd", rs1_idx[1], 5'd0);
        step(2'b11, ADDIA, ADDB, 2'b01, 0);
        chk("pre_fl_ready", ready, 1'b0);
        step(2'b11, ADDI3, ADD4, 2'b00, 1);
        chk("fl_vld0", pipe_vld[0], 1'b0);
        chk("fl_vld1", pipe_vld[1], 1'b0);
        chk("fl_ready", ready, 1'b1);
        chk("fl_rs1_vld0", rs1_vld[0], 1'b0);
        chk("fl_cnt", stall_cnt, 16'd5);
        step(2'b00, 0, 0, 2'b00, 0);
        chk("fl_push_gone", pipe_vld[0], 1'b0);

        // asynchronous reset with three entries buffered
        step(2'b11, ADDI1, ADDI2, 2'b01, 0);
        step(2'b01, ADDI3, 0, 2'b01, 0);
        chk("mid_ready", ready, 1'b0);
        chk("mid_cnt", stall_cnt, 16'd6);
        #2 rst = 1'b1;
        #1;
        chk("arst_ready", ready, 1'b1);
        chk("arst_cnt", stall_cnt, 16'd0);
        chk("arst_inst0", iex_inst[0], 32'd0);
        chk("arst_rs1_vld0", rs1_vld[0], 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        step(2'b00, 0, 0, 2'b00, 0);
        step(2'b00, 0, 0, 2'b00, 0);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
